// File: rtl/bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bus_arbiter_pkg
// Shared definitions for the four-master bus arbiter:
//   NUM_MASTERS, OWNER_W : master count and width of an owner index
//   MASTER_0..MASTER_3   : master index constants
//   arb_state_e          : arbiter FSM state encoding (IDLE / GRANT)
//   rr_pick()            : round-robin search helper
// -----------------------------------------------------------------------------
package bus_arbiter_pkg;

    localparam int NUM_MASTERS = 4;
    localparam int OWNER_W     = 2;

    typedef logic [OWNER_W-1:0]     owner_t;
    typedef logic [NUM_MASTERS-1:0] master_vec_t;

    localparam owner_t MASTER_0 = 2'd0;
    localparam owner_t MASTER_1 = 2'd1;
    localparam owner_t MASTER_2 = 2'd2;
    localparam owner_t MASTER_3 = 2'd3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic   found;
        owner_t idx;
    } rr_pick_t;

    // Searches active-high requests starting at i_start and wrapping 3->0.
    // The slot just before i_start (the previous owner) is visited last.
    // Walking the offsets from far to near lets the nearest hit overwrite
    // any farther one, so the loop body needs no early exit.
    function automatic rr_pick_t rr_pick(input master_vec_t i_req, input owner_t i_start);
        rr_pick_t w_res;
        owner_t   w_cand;
        w_res.found = 1'b0;
        w_res.idx   = i_start;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            w_cand = i_start + OWNER_W'(i);
            if (i_req[w_cand]) begin
                w_res.found = 1'b1;
                w_res.idx   = w_cand;
            end
        end
        return w_res;
    endfunction

endpackage : bus_arbiter_pkg

// File: rtl/global_defs_pkg.sv
// -----------------------------------------------------------------------------
// global_defs_pkg
// Project-wide bus definitions shared by every bus-interface block:
//   ADDR_W / DATA_W     : word-address and data widths of the system bus
//   ENABLE_ / DISABLE_  : levels of active-low strobes (asserted / negated)
//   READ / WRITE        : encoding of the single-bit bus direction signal
// -----------------------------------------------------------------------------
package global_defs_pkg;

    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

endpackage : global_defs_pkg

// File: rtl/bus_master_mux.sv
// -----------------------------------------------------------------------------
// bus_master_mux
// Combinational steering of the owning master's signals onto the shared bus.
// While nobody owns the bus it is parked: address/data zero, direction READ,
// strobe negated.
// Ports:
//   i_owner      : registered owner index
//   i_busy       : high while a grant is active
//   i_addr[]     : per-master word address
//   i_as_n[]     : per-master address strobe (active-low)
//   i_rw[]       : per-master direction
//   i_wr_data[]  : per-master write data
//   o_addr, o_as_n, o_rw, o_wr_data : shared bus
// -----------------------------------------------------------------------------
module bus_master_mux
    import global_defs_pkg::*;
    import bus_arbiter_pkg::*;
(
    input  owner_t             i_owner,
    input  logic               i_busy,
    input  logic [ADDR_W-1:0]  i_addr    [NUM_MASTERS],
    input  logic               i_as_n    [NUM_MASTERS],
    input  logic               i_rw      [NUM_MASTERS],
    input  logic [DATA_W-1:0]  i_wr_data [NUM_MASTERS],
    output logic [ADDR_W-1:0]  o_addr,
    output logic               o_as_n,
    output logic               o_rw,
    output logic [DATA_W-1:0]  o_wr_data
);

    // NOTE: every output gets a parked default before the conditional
    // override; leaving any path unassigned in always_comb infers a latch.
    always_comb begin
        o_addr    = '0;
        o_as_n    = DISABLE_;
        o_rw      = READ;
        o_wr_data = '0;
        if (i_busy) begin
            o_addr    = i_addr[i_owner];
            o_as_n    = i_as_n[i_owner];
            o_rw      = i_rw[i_owner];
            o_wr_data = i_wr_data[i_owner];
        end
    end

endmodule : bus_master_mux

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Four-master round-robin bus arbiter, non-preemptive, one-clock grant
// latency, back-to-back handover between tenures.
// Ports:
//   clk          : system clock, rising edge
//   reset        : asynchronous active-high reset
//   m_req_n      : per-master request, active-low
//   m_grnt_n     : per-master grant, active-low, registered, one-hot-low
//   m_addr[]     : per-master word address
//   m_as_n[]     : per-master address strobe, active-low
//   m_rw[]       : per-master direction (READ/WRITE)
//   m_wr_data[]  : per-master write data
//   bus_addr, bus_as_n, bus_rw, bus_wr_data : shared bus from the owner
//   bus_owner    : index of the granted master (valid while bus_busy)
//   bus_busy     : high while a grant is held
// -----------------------------------------------------------------------------
module bus_arbiter
    import global_defs_pkg::*;
    import bus_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         m_req_n,
    output logic [3:0]         m_grnt_n,
    input  logic [ADDR_W-1:0]  m_addr    [NUM_MASTERS],
    input  logic               m_as_n    [NUM_MASTERS],
    input  logic               m_rw      [NUM_MASTERS],
    input  logic [DATA_W-1:0]  m_wr_data [NUM_MASTERS],
    output logic [ADDR_W-1:0]  bus_addr,
    output logic               bus_as_n,
    output logic               bus_rw,
    output logic [DATA_W-1:0]  bus_wr_data,
    output logic [1:0]         bus_owner,
    output logic               bus_busy
);

    arb_state_e  r_state;
    owner_t      r_owner;
    owner_t      r_last_owner;
    master_vec_t r_grnt_n;

    arb_state_e  w_state_nxt;
    owner_t      w_owner_nxt;
    owner_t      w_last_owner_nxt;
    master_vec_t w_grnt_n_nxt;

    master_vec_t w_req;
    rr_pick_t    w_pick;

    assign w_req = ~m_req_n;

    // The search always starts one past the most recent owner. In GRANT that
    // is the current owner, so the releasing master lands at the end of the
    // order; in IDLE it is the remembered last owner.
    assign w_pick = rr_pick(w_req, r_last_owner + 1'b1);

    // -------------------------------------------------------------------------
    // State register. Reset leaves last_owner at 3 so the first contended
    // grant goes to master 0.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_owner      <= MASTER_0;
            r_last_owner <= MASTER_3;
            r_grnt_n     <= '1;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_last_owner <= w_last_owner_nxt;
            r_grnt_n     <= w_grnt_n_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_last_owner_nxt = r_last_owner;
        w_grnt_n_nxt     = r_grnt_n;

        unique case (r_state)
            ST_IDLE: begin
                if (w_pick.found) begin
                    w_state_nxt      = ST_GRANT;
                    w_owner_nxt      = w_pick.idx;
                    w_last_owner_nxt = w_pick.idx;
                    w_grnt_n_nxt     = ~(master_vec_t'(1) << w_pick.idx);
                end
            end

            ST_GRANT: begin
                // No preemption: nothing moves while the owner keeps its
                // request asserted.
                if (!w_req[r_owner]) begin
                    if (w_pick.found) begin
                        w_owner_nxt      = w_pick.idx;
                        w_last_owner_nxt = w_pick.idx;
                        w_grnt_n_nxt     = ~(master_vec_t'(1) << w_pick.idx);
                    end else begin
                        w_state_nxt  = ST_IDLE;
                        w_grnt_n_nxt = '1;
                    end
                end
            end

            default: begin
                w_state_nxt  = ST_IDLE;
                w_grnt_n_nxt = '1;
            end
        endcase
    end

    assign m_grnt_n  = r_grnt_n;
    assign bus_owner = r_owner;
    assign bus_busy  = (r_state == ST_GRANT);

    // Driven from registered state only, so reset parks the bus immediately.
    bus_master_mux u_bus_master_mux (
        .i_owner   (r_owner),
        .i_busy    (bus_busy),
        .i_addr    (m_addr),
        .i_as_n    (m_as_n),
        .i_rw      (m_rw),
        .i_wr_data (m_wr_data),
        .o_addr    (bus_addr),
        .o_as_n    (bus_as_n),
        .o_rw      (bus_rw),
        .o_wr_data (bus_wr_data)
    );

endmodule : bus_arbiter
